// File: rtl/gpp_calc_pkg.sv
// Shared types and constants for the calculator ALU sequencer.
// Optional feature macro: ALU_SEQ_BRANCH_EN (adds BRZ/BRN).
package gpp_calc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned OPC_W  = 6;
    localparam int unsigned IMM_W  = 9;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LDX = 6'b000001;
    localparam logic [OPC_W-1:0] OP_LDY = 6'b000010;
    localparam logic [OPC_W-1:0] OP_LDA = 6'b000011;
    localparam logic [OPC_W-1:0] OP_ADD = 6'b001101;
    localparam logic [OPC_W-1:0] OP_BRZ = 6'b100000;
    localparam logic [OPC_W-1:0] OP_BRN = 6'b100001;
    localparam logic [OPC_W-1:0] OP_HLT = 6'b111111;

    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 3;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        LD_NONE,
        LD_X,
        LD_Y,
        LD_A
    } ld_tgt_t;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic             rsel;
        logic [IMM_W-1:0] imm;
    } instr_t;

    // Sign-extend the 9-bit immediate to the datapath width
    function automatic logic [DATA_W-1:0] sext9(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Fetch and ALU side signals of the sequencer.
interface alu_seq_ctrl_if;
    import gpp_calc_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    instr_t              instr;
    logic [PC_W-1:0]     pc;
    logic                alu_en;
    logic [OPC_W-1:0]    alu_opcode;
    logic                alu_ra;
    logic [DATA_W-1:0]   alu_imm;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   x;
    logic [DATA_W-1:0]   y;
    logic [DATA_W-1:0]   alu_res;
    logic [FLAG_W-1:0]   alu_flags;
    logic [FLAG_W-1:0]   flags;
    logic                busy;
    logic                halted;
    logic                illegal;

    // Fetch unit plus external ALU
    modport master (
        output instr_valid, instr, alu_res, alu_flags,
        input  instr_ready, pc, alu_en, alu_opcode, alu_ra, alu_imm,
               acc, x, y, flags, busy, halted, illegal
    );

    // Sequencer
    modport slave (
        input  instr_valid, instr, alu_res, alu_flags,
        output instr_ready, pc, alu_en, alu_opcode, alu_ra, alu_imm,
               acc, x, y, flags, busy, halted, illegal
    );

endinterface

// File: rtl/alu_seq_decode.sv
// Combinational opcode decode for the ALU sequencer.
// BRZ/BRN are decoded only when ALU_SEQ_BRANCH_EN is defined.
module alu_seq_decode
    import gpp_calc_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output state_t           next_state_c,
    output ld_tgt_t          ld_tgt_c,
    output logic             is_branch_c,
    output logic             illegal_c
);

    // Map opcode to the state after DECODE and its side effects
    always_comb begin
        next_state_c = IDLE;
        ld_tgt_c     = LD_NONE;
        is_branch_c  = 1'b0;
        illegal_c    = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_LDX: ld_tgt_c = LD_X;
            OP_LDY: ld_tgt_c = LD_Y;
            OP_LDA: ld_tgt_c = LD_A;
            OP_ADD: next_state_c = EXEC;
            OP_HLT: next_state_c = HALT;
`ifdef ALU_SEQ_BRANCH_EN
            OP_BRZ, OP_BRN: is_branch_c = 1'b1;
`endif
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Single-issue sequencer driving the external calculator ALU.
// Owns ACC/X/Y/flags; ADD is issued to the ALU for one EXEC cycle.
// Optional feature macro: ALU_SEQ_BRANCH_EN (BRZ/BRN, resolved in DECODE).
module alu_seq_ctrl
    import gpp_calc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_seq_ctrl_if.slave bus
);

    state_t              state;
    instr_t              ir;
    logic [PC_W-1:0]     pc_q;
    logic [DATA_W-1:0]   acc_q, x_q, y_q;
    logic [FLAG_W-1:0]   flags_q;
    logic                alu_en_q, alu_ra_q;
    logic [OPC_W-1:0]    alu_opcode_q;
    logic [DATA_W-1:0]   alu_imm_q;
    logic                ready_q, busy_q, halted_q, illegal_q;

    state_t              dec_next_c;
    ld_tgt_t             dec_ld_c;
    logic                dec_branch_c;
    logic                dec_illegal_c;
    logic                br_cond_c;
    logic                take_br_c;

    alu_seq_decode u_decode (
        .opcode       (ir.opcode),
        .next_state_c (dec_next_c),
        .ld_tgt_c     (dec_ld_c),
        .is_branch_c  (dec_branch_c),
        .illegal_c    (dec_illegal_c)
    );

    // Branch condition: opcode bit 0 picks N (BRN) over Z (BRZ)
`ifdef ALU_SEQ_BRANCH_EN
    assign br_cond_c = ir.opcode[0] ? flags_q[FLAG_N] : flags_q[FLAG_Z];
`else
    assign br_cond_c = 1'b0;
`endif
    assign take_br_c = dec_branch_c & br_cond_c;

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ir           <= '0;
            pc_q         <= '0;
            acc_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            flags_q      <= '0;
            alu_en_q     <= 1'b0;
            alu_ra_q     <= 1'b0;
            alu_opcode_q <= '0;
            alu_imm_q    <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        ir      <= bus.instr;
                        pc_q    <= pc_q + PC_W'(1);
                        state   <= DECODE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                DECODE: begin
                    state <= dec_next_c;
                    case (dec_ld_c)
                        LD_X:    x_q   <= sext9(ir.imm);
                        LD_Y:    y_q   <= sext9(ir.imm);
                        LD_A:    acc_q <= sext9(ir.imm);
                        default: ;
                    endcase
                    if (dec_illegal_c) begin
                        illegal_q <= 1'b1;
                    end
                    // pc already points past the branch, so subtract one
                    if (take_br_c) begin
                        pc_q <= pc_q + PC_W'(sext9(ir.imm)) - PC_W'(1);
                    end
                    case (dec_next_c)
                        IDLE: begin
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                        EXEC: begin
                            alu_en_q     <= 1'b1;
                            alu_opcode_q <= ir.opcode;
                            alu_ra_q     <= ir.rsel;
                            alu_imm_q    <= sext9(ir.imm);
                        end
                        HALT:    halted_q <= 1'b1;
                        default: ;
                    endcase
                end
                EXEC: begin
                    alu_en_q <= 1'b0;
                    state    <= WB;
                end
                WB: begin
                    acc_q   <= bus.alu_res;
                    flags_q <= bus.alu_flags;
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.pc          = pc_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_opcode  = alu_opcode_q;
    assign bus.alu_ra      = alu_ra_q;
    assign bus.alu_imm     = alu_imm_q;
    assign bus.acc         = acc_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.flags       = flags_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural ALU model.
module tb_alu_seq_ctrl;
    import gpp_calc_pkg::*;

    logic clk;
    logic rst;
    int unsigned total;
    int unsigned passed;

    alu_seq_ctrl_if bus();

    alu_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: operand A is ACC when imm is zero, else the immediate
    logic [15:0] op_a, op_b;
    logic [16:0] sum;
    always_comb begin
        op_a = (bus.alu_imm == 16'h0) ? bus.acc : bus.alu_imm;
        op_b = bus.alu_ra ? bus.y : bus.x;
        sum  = {1'b0, op_a} + {1'b0, op_b};
        bus.alu_res      = sum[15:0];
        bus.alu_flags[0] = (op_a[15] == op_b[15]) && (sum[15] != op_a[15]);
        bus.alu_flags[1] = sum[16];
        bus.alu_flags[2] = sum[15];
        bus.alu_flags[3] = (sum[15:0] == 16'h0);
    end

    typedef struct {
        logic [15:0] w;
        logic [15:0] acc;
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  flags;
        logic [7:0]  pc;
        int          en;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    // Present a word and wait for the accept edge
    task automatic issue(input logic [15:0] w);
        int n;
        n = 0;
        @(negedge clk);
        bus.instr       = instr_t'(w);
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            $display("FAIL issue_timeout: got ready=0 expected ready=1 for word 0x%0h", w);
        end
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
    endtask

    // Wait until back in IDLE (or halted), counting alu_en cycles
    task automatic wait_done(output int en_cnt);
        int n;
        n = 0;
        en_cnt = 0;
        do begin
            @(negedge clk);
            if (bus.alu_en) en_cnt++;
            n++;
        end while (bus.busy && !bus.halted && n < 20);
        if (n >= 20) begin
            total++;
            $display("FAIL done_timeout: got busy=1 expected busy=0");
        end
    endtask

    task automatic run(input logic [15:0] w);
        int en;
        issue(w);
        wait_done(en);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int en;
        int k, last, n_acc, rdy_cnt;
        total  = 0;
        passed = 0;

        tbl[0]  = '{16'h0405, 16'h0000, 16'h0005, 16'h0000, 4'h0, 8'd1,  0};
        tbl[1]  = '{16'h0CFF, 16'h00FF, 16'h0005, 16'h0000, 4'h0, 8'd2,  0};
        tbl[2]  = '{16'h3400, 16'h0104, 16'h0005, 16'h0000, 4'h0, 8'd3,  1};
        tbl[3]  = '{16'h09FF, 16'h0104, 16'h0005, 16'hFFFF, 4'h0, 8'd4,  0};
        tbl[4]  = '{16'h0C01, 16'h0001, 16'h0005, 16'hFFFF, 4'h0, 8'd5,  0};
        tbl[5]  = '{16'h3600, 16'h0000, 16'h0005, 16'hFFFF, 4'hA, 8'd6,  1};
        tbl[6]  = '{16'h0500, 16'h0000, 16'hFF00, 16'hFFFF, 4'hA, 8'd7,  0};
        tbl[7]  = '{16'h0000, 16'h0000, 16'hFF00, 16'hFFFF, 4'hA, 8'd8,  0};
        tbl[8]  = '{16'h3403, 16'hFF03, 16'hFF00, 16'hFFFF, 4'h4, 8'd9,  1};
        tbl[9]  = '{16'h08FF, 16'hFF03, 16'hFF00, 16'h00FF, 4'h4, 8'd10, 0};
        tbl[10] = '{16'h3701, 16'h0000, 16'hFF00, 16'h00FF, 4'hA, 8'd11, 1};

        rst = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_pc",     32'(bus.pc), 32'h0);
        check("rst_ready",  32'(bus.instr_ready), 32'h1);
        check("rst_busy",   32'(bus.busy), 32'h0);
        check("rst_alu_en", 32'(bus.alu_en), 32'h0);
        check("rst_acc",    32'(bus.acc), 32'h0);
        check("rst_flags",  32'(bus.flags), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_illegal",32'(bus.illegal), 32'h0);
        rst = 1'b1;

        // Reset in the middle of EXEC discards the ADD
        run(16'h0405);
        issue(16'h3407);
        @(negedge clk);
        @(negedge clk);
        check("mid_exec_en",  32'(bus.alu_en), 32'h1);
        check("mid_exec_imm", 32'(bus.alu_imm), 32'h0007);
        rst = 1'b0;
        #1;
        check("mrst_en",     32'(bus.alu_en), 32'h0);
        check("mrst_opcode", 32'(bus.alu_opcode), 32'h0);
        check("mrst_imm",    32'(bus.alu_imm), 32'h0);
        check("mrst_x",      32'(bus.x), 32'h0);
        check("mrst_pc",     32'(bus.pc), 32'h0);
        check("mrst_ready",  32'(bus.instr_ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_acc_after", 32'(bus.acc), 32'h0);
        check("mrst_busy_after", 32'(bus.busy), 32'h0);

        // Table of single instructions
        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].w);
            wait_done(en);
            check($sformatf("v%0d_acc", i),   32'(bus.acc),   32'(tbl[i].acc));
            check($sformatf("v%0d_x", i),     32'(bus.x),     32'(tbl[i].x));
            check($sformatf("v%0d_y", i),     32'(bus.y),     32'(tbl[i].y));
            check($sformatf("v%0d_flags", i), 32'(bus.flags), 32'(tbl[i].flags));
            check($sformatf("v%0d_pc", i),    32'(bus.pc),    32'(tbl[i].pc));
            check($sformatf("v%0d_en", i),    32'(en),        32'(tbl[i].en));
            check($sformatf("v%0d_ill", i),   32'(bus.illegal), 32'h0);
        end

        // Back-to-back ADD ACC+Y with valid held high
        k = 0;
        last = -1;
        n_acc = 0;
        @(negedge clk);
        bus.instr = instr_t'(16'h3600);
        bus.instr_valid = 1'b1;
        while (n_acc < 3 && k < 40) begin
            if (bus.instr_ready) begin
                if (last >= 0) check("b2b_interval", 32'(k - last), 32'd4);
                last = k;
                n_acc++;
            end
            if (n_acc < 3) begin
                @(negedge clk);
                k++;
            end
        end
        check("b2b_accepts", 32'(n_acc), 32'd3);
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        wait_done(en);
        check("b2b_acc",   32'(bus.acc), 32'h02FD);
        check("b2b_pc",    32'(bus.pc), 32'd14);
        check("b2b_flags", 32'(bus.flags), 32'h0);

        // Unknown opcode, then HLT
        run(16'h5400);
        check("ill_flag", 32'(bus.illegal), 32'h1);
        check("ill_pc",   32'(bus.pc), 32'd15);
        check("ill_acc",  32'(bus.acc), 32'h02FD);
        run(16'hFC00);
        check("hlt_halted", 32'(bus.halted), 32'h1);
        check("hlt_busy",   32'(bus.busy), 32'h1);
        check("hlt_pc",     32'(bus.pc), 32'd16);
        check("hlt_ill",    32'(bus.illegal), 32'h1);
        rdy_cnt = 0;
        bus.instr = instr_t'(16'h0401);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.instr_ready) rdy_cnt++;
        end
        bus.instr_valid = 1'b0;
        check("hlt_ready_stuck", 32'(rdy_cnt), 32'd0);
        check("hlt_pc_hold",     32'(bus.pc), 32'd16);
        check("hlt_x_hold",      32'(bus.x), 32'hFF00);
        do_reset();
        #1;
        check("post_hlt_halted", 32'(bus.halted), 32'h0);
        check("post_hlt_ill",    32'(bus.illegal), 32'h0);
        check("post_hlt_ready",  32'(bus.instr_ready), 32'h1);

`ifdef ALU_SEQ_BRANCH_EN
        // Taken BRZ at pc 10 with offset -2
        for (int i = 0; i < 7; i++) run(16'h0000);
        run(16'h09FF);
        run(16'h0C01);
        run(16'h3600);
        check("brz_pre_flags", 32'(bus.flags), 32'hA);
        check("brz_pre_pc",    32'(bus.pc), 32'd10);
        run(16'h81FE);
        check("brz_taken_pc",  32'(bus.pc), 32'd8);
        check("brz_flags",     32'(bus.flags), 32'hA);
        check("brz_ill",       32'(bus.illegal), 32'h0);
        do_reset();
        for (int i = 0; i < 10; i++) run(16'h0000);
        run(16'h81FE);
        check("brz_fall_pc",   32'(bus.pc), 32'd11);
`else
        // Branch opcodes are illegal in the default build
        run(16'h8000);
        check("brz_illegal", 32'(bus.illegal), 32'h1);
        check("brz_pc",      32'(bus.pc), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
